// File: rtl/soc_gpio_irq_pkg.sv
// Shared definitions for the GPIO interrupt aggregator: register offsets,
// hold-off FSM encoding and the default read-data pattern of the GPIO mux.
package soc_gpio_irq_pkg;

  // Register offsets, decoded from addr[4:2]
  localparam logic [2:0] OFF_RAW  = 3'd0;
  localparam logic [2:0] OFF_PEND = 3'd1;
  localparam logic [2:0] OFF_MASK = 3'd2;
  localparam logic [2:0] OFF_MODE = 3'd3;
  localparam logic [2:0] OFF_ID   = 3'd4;
  localparam logic [2:0] OFF_HOLD = 3'd5;

  // Returned for unmapped offsets; the SoC GPIO mux uses the same pattern
  localparam logic [31:0] DEFAULT_DATA = 32'h1bad_c0de;

  // Hold-off FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_HOLD   = 2'd2
  } irq_state_e;

endpackage

// File: rtl/soc_gpio_irq_prio.sv
// Lowest-index-wins priority encoder: bank a (bit 0) has the highest priority.
module soc_gpio_irq_prio #(
  parameter int NBANK = 7,
  parameter int IW    = 3
) (
  input  logic [NBANK-1:0] i_act,
  output logic             o_valid,
  output logic [IW-1:0]    o_id
);

  // Scan downward so the last (lowest) set index is the one that remains.
  always_comb begin
    o_valid = |i_act;
    o_id    = {IW{1'b0}};
    for (int i = NBANK - 1; i >= 0; i--) begin
      o_id = i_act[i] ? IW'(i) : o_id;
    end
  end

endmodule

// File: rtl/soc_gpio_irq_ctrl.sv
// GPIO interrupt aggregator: per-bank level/edge pending latch, mask, fixed
// priority and a registered CPU interrupt with programmable low-time hold-off.
// Wishbone slave with one wait state and single-cycle ack pulses.
module soc_gpio_irq_ctrl
  import soc_gpio_irq_pkg::*;
#(
  parameter int NBANK = 7,
  parameter int HW    = 16
) (
  input  logic             gpio_clk_i,
  input  logic             gpio_rst_i,
  input  logic [31:0]      irq_data_i,
  output logic [31:0]      irq_data_o,
  input  logic [31:0]      irq_addr_i,
  input  logic [3:0]       irq_sel_i,
  input  logic             irq_we_i,
  input  logic             irq_cyc_i,
  input  logic             irq_stb_i,
  output logic             irq_ack_o,
  output logic             irq_err_o,
  output logic             irq_rty_o,
  input  logic [NBANK-1:0] gpio_inta_i,
  output logic             irq_o,
  output logic [2:0]       irq_id_o
);

  localparam logic [HW-1:0] CNT_ZERO = {HW{1'b0}};
  localparam logic [HW-1:0] CNT_ONE  = HW'(1);

  logic             r_ack;
  logic [31:0]      r_rdata;
  logic [NBANK-1:0] r_inta_q;
  logic [NBANK-1:0] r_pend;
  logic [NBANK-1:0] r_mask;
  logic [NBANK-1:0] r_mode;
  logic [HW-1:0]    r_hold;
  logic [HW-1:0]    r_cnt;
  logic             r_irq;
  logic [2:0]       r_id;
  irq_state_e       r_state;
  irq_state_e       w_next;

  logic             w_req;
  logic             w_wr;
  logic [2:0]       w_off;
  logic [NBANK-1:0] w_act;
  logic [NBANK-1:0] w_rise;
  logic [NBANK-1:0] w_clr;
  logic [NBANK-1:0] w_pend_nxt;
  logic             w_valid;
  logic [2:0]       w_id;
  logic [31:0]      w_rdata;
  logic             w_irq_d;
  logic             w_load_cnt;
  logic             w_unused;

  // A request is accepted only when ack is low, which yields one wait state
  assign w_req  = irq_cyc_i & irq_stb_i & ~r_ack;
  assign w_wr   = w_req & irq_we_i;
  assign w_off  = irq_addr_i[4:2];
  assign w_act  = r_pend & r_mask;
  assign w_rise = gpio_inta_i & ~r_inta_q;

  // Edge banks: set beats clear. Level banks just follow the input.
  assign w_pend_nxt = (r_mode & (w_rise | (r_pend & ~w_clr))) | (~r_mode & gpio_inta_i);

  assign irq_data_o = r_rdata;
  assign irq_ack_o  = r_ack;
  assign irq_err_o  = 1'b0;
  assign irq_rty_o  = 1'b0;
  assign irq_o      = r_irq;
  assign irq_id_o   = r_id;

  // Byte selects and undecoded address/data bits are intentionally ignored
  assign w_unused = ^{irq_sel_i, irq_addr_i[31:5], irq_addr_i[1:0], irq_data_i[31:HW]};

  soc_gpio_irq_prio #(
    .NBANK (NBANK),
    .IW    (3)
  ) u_prio (
    .i_act   (w_act),
    .o_valid (w_valid),
    .o_id    (w_id)
  );

  // Write-1-to-clear mask for PEND, only on an accepted PEND write
  always_comb begin
    if (w_wr && (w_off == OFF_PEND)) begin
      w_clr = irq_data_i[NBANK-1:0];
    end else begin
      w_clr = {NBANK{1'b0}};
    end
  end

  // Read-data mux; unused upper bits stay 0
  always_comb begin
    w_rdata = 32'd0;
    case (w_off)
      OFF_RAW:  w_rdata[NBANK-1:0] = r_inta_q;
      OFF_PEND: w_rdata[NBANK-1:0] = r_pend;
      OFF_MASK: w_rdata[NBANK-1:0] = r_mask;
      OFF_MODE: w_rdata[NBANK-1:0] = r_mode;
      OFF_ID: begin
        w_rdata[31]  = w_valid;
        w_rdata[2:0] = w_id;
      end
      OFF_HOLD: w_rdata[HW-1:0] = r_hold;
      default:  w_rdata = DEFAULT_DATA;
    endcase
  end

  // Bus registers, input history and the per-bank pending/mask/mode/hold state
  always_ff @(posedge gpio_clk_i or posedge gpio_rst_i) begin
    if (gpio_rst_i) begin
      r_ack    <= 1'b0;
      r_rdata  <= 32'd0;
      r_inta_q <= {NBANK{1'b0}};
      r_pend   <= {NBANK{1'b0}};
      r_mask   <= {NBANK{1'b0}};
      r_mode   <= {NBANK{1'b0}};
      r_hold   <= CNT_ZERO;
    end else begin
      r_ack    <= w_req;
      r_rdata  <= w_req ? w_rdata : 32'd0;
      r_inta_q <= gpio_inta_i;
      r_pend   <= w_pend_nxt;
      if (w_wr) begin
        case (w_off)
          OFF_MASK: r_mask <= irq_data_i[NBANK-1:0];
          OFF_MODE: r_mode <= irq_data_i[NBANK-1:0];
          OFF_HOLD: r_hold <= irq_data_i[HW-1:0];
          default:  r_mask <= r_mask;
        endcase
      end
    end
  end

  // Hold-off FSM state register
  always_ff @(posedge gpio_clk_i or posedge gpio_rst_i) begin
    if (gpio_rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Hold-off FSM next state; leaving HOLD straight into ASSERT keeps the
  // low time at exactly HOLD cycles when a new request is already waiting
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (|w_act) w_next = ST_ASSERT;
        else        w_next = ST_IDLE;
      end
      ST_ASSERT: begin
        if (|w_act)                  w_next = ST_ASSERT;
        else if (r_hold == CNT_ZERO) w_next = ST_IDLE;
        else                         w_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (r_cnt <= CNT_ONE) w_next = (|w_act) ? ST_ASSERT : ST_IDLE;
        else                  w_next = ST_HOLD;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Hold-off FSM outputs: request level and counter load strobe
  always_comb begin
    w_irq_d = (w_next == ST_ASSERT);
    if ((r_state == ST_ASSERT) && (w_next == ST_HOLD)) begin
      w_load_cnt = 1'b1;
    end else begin
      w_load_cnt = 1'b0;
    end
  end

  // Registered interrupt, ID (held while deasserted) and hold-off counter
  always_ff @(posedge gpio_clk_i or posedge gpio_rst_i) begin
    if (gpio_rst_i) begin
      r_irq <= 1'b0;
      r_id  <= 3'd0;
      r_cnt <= CNT_ZERO;
    end else begin
      r_irq <= w_irq_d;
      if (w_irq_d) begin
        r_id <= w_id;
      end
      if (w_load_cnt) begin
        r_cnt <= r_hold;
      end else if (r_state == ST_HOLD) begin
        r_cnt <= r_cnt - CNT_ONE;
      end
    end
  end

endmodule

// File: doc/soc_gpio_irq_ctrl.md
# soc_gpio_irq_ctrl

Interrupt aggregator directly downstream of the SoC GPIO block. Consumes the seven per-bank GPIO interrupt lines (banks a..g), latches or tracks them per bank, and applies a mask and fixed priority. Drives a single registered interrupt request, with programmable hold-off, to the CPU PIC. It is a Wishbone slave on the same bus clock as the GPIO banks.

## Interface
Parameters:
- NBANK, 7, number of GPIO bank interrupt inputs (bit 0 = bank a)
- HW, 16, width of hold-off counter/register

Ports:
- gpio_clk_i  in  1  bus clock, all logic on rising edge
- gpio_rst_i  in  1  reset, asynchronous, active-high
- irq_data_i  in  32  Wishbone write data
- irq_data_o  out  32  Wishbone read data
- irq_addr_i  in  32  Wishbone address; only [4:2] decoded
- irq_sel_i  in  4  byte selects; ignored, all accesses are full word
- irq_we_i  in  1  write enable
- irq_cyc_i  in  1  cycle
- irq_stb_i  in  1  strobe
- irq_ack_o  out  1  acknowledge
- irq_err_o  out  1  tied 0
- irq_rty_o  out  1  tied 0
- gpio_inta_i  in  NBANK  level interrupts from GPIO banks a..g
- irq_o  out  1  interrupt request to CPU PIC
- irq_id_o  out  3  index of highest-priority active bank

## Operation
- Register map, by addr[4:2]:
  - 0 RAW: read-only; registered gpio_inta_i.
  - 1 PEND: read; write-1-to-clear.
  - 2 MASK: read/write; 1 = enabled.
  - 3 MODE: read/write; 0 = level, 1 = edge.
  - 4 ID: read-only; bit31 = valid, [2:0] = irq_id_o.
  - 5 HOLD: read/write; [HW-1:0].
  - 6, 7: read 32'h1bad_c0de; writes are ignored; the access is still acked.
- Unused upper bits read 0.
- inta_q <= gpio_inta_i each cycle. This single register is the edge-detect history. No synchronizer is needed because the source is on the same clock.
- Edge mode bank: pend[i] is set when gpio_inta_i[i] & ~inta_q[i]. It is cleared by a PEND write with bit i = 1. If a set and a clear occur in the same cycle, set wins.
- Level mode bank: pend[i] <= gpio_inta_i[i]. PEND writes have no effect on that bank.
- A MODE change takes effect on the next cycle. It does not clear pend.
- Active vector act = pend & mask.
- ID: lowest set index of act, so bank a has the highest priority. When act == 0, valid = 0 and the ID field reads 0.
- Hold-off FSM, states IDLE, ASSERT, HOLD:
  - IDLE -> ASSERT when |act; irq_o <= 1.
  - ASSERT -> IDLE when act == 0 and HOLD == 0; irq_o <= 0.
  - ASSERT -> HOLD when act == 0 and HOLD != 0; irq_o <= 0; cnt <= HOLD.
  - HOLD: cnt decrements each cycle. At cnt == 1 the FSM goes to IDLE, so the low time is exactly HOLD cycles.
- irq_id_o is registered alongside irq_o. It holds its last value while irq_o = 0.

## Timing
- Reset values: irq_data_o = 0, irq_ack_o = 0, irq_o = 0, irq_id_o = 0, pend = 0, mask = 0, mode = 0, hold = 0, inta_q = 0, cnt = 0, FSM = IDLE.
- Reset is asynchronous. Asserting it mid-transaction or mid-hold-off returns every register to its reset value immediately, with no ack issued.
- Bus handshake:
  - irq_ack_o <= cyc & stb & ~irq_ack_o, giving one wait state and a one-cycle ack pulse.
  - A held request produces ack on every other cycle.
  - Read data is registered and valid in the ack cycle.
  - Writes commit on the clock edge that raises ack.
- Interrupt latency:
  - Edge on gpio_inta_i at edge n: pend set at n+1, irq_o high at n+2.
  - Level mode: same timing, n+2.
- Clear latency:
  - PEND write acked at edge m clears pend at m; irq_o falls at m+1.
  - A MASK write has the same timing as a PEND clear.

## Structure
- Shared package soc_gpio_irq_pkg holds:
  - register offset constants (RAW..HOLD = 0..5);
  - the FSM state encoding (IDLE, ASSERT, HOLD);
  - the 32'h1bad_c0de default data constant, shared with the SoC GPIO mux.
- One sub-module, soc_gpio_irq_prio: combinational NBANK-input lowest-index priority encoder producing the valid flag and the index.
- Everything else (register file, FSM, counter) stays in the top module.

## Test plan
- Reset, then read all six registers. Expect 0 everywhere, irq_o = 0, and reads of offsets 6 and 7 returning 32'h1bad_c0de with ack.
- MODE = 7'h7F, MASK = 7'h04, pulse gpio_inta_i[2] for 1 cycle at edge n:
  - PEND reads 0x04; irq_o high at n+2; irq_id_o = 2.
  - Write PEND = 0x04: irq_o low the cycle after ack.
- Level mode, MASK = 7'h7F, gpio_inta_i = 7'b1010000:
  - ID reads 0x80000004.
  - Dropping bit 4 changes ID to 0x80000006.
  - Writing PEND = 0x7F leaves PEND = 0x40.
- Edge mode: a new edge on bank 1 in the same cycle as a PEND write clearing bit 1 -> PEND bit 1 stays 1.
- HOLD = 5, level mode, bank 0 pulsed high twice with a 1-cycle gap -> irq_o low for exactly 5 cycles between the two assertions.
- Assert gpio_rst_i mid hold-off with irq_o high/pending -> all outputs 0 immediately and MASK reads 0 after release.
